// File: rtl/serial_bit_streamer_if.sv
// serial_bit_streamer_if: word handshake, abort and serial output bundle
interface serial_bit_streamer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data_in;
  logic data_valid;
  logic data_ready;
  logic abort;
  logic bit_out;
  logic bit_valid;
  logic last_bit;
  modport master (output data_in, data_valid, abort, input data_ready, bit_out, bit_valid, last_bit);
  modport slave (input data_in, data_valid, abort, output data_ready, bit_out, bit_valid, last_bit);
endinterface

// File: rtl/serial_bit_streamer.sv
// serial_bit_streamer: gapless parallel-to-serial shifter feeding a sequence detector
module serial_bit_streamer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT = 1'b0
) (
  input logic clk,
  input logic rst_n,
  serial_bit_streamer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic last, accept;
  assign last = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign accept = bus.data_valid && bus.data_ready;
  assign bus.data_ready = (state == IDLE) || last;
  assign bus.bit_valid = (state == SHIFT);
  assign bus.last_bit = last;
  assign bus.bit_out = (state == SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_BIT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
    end else if (bus.abort) begin
      state <= IDLE;
      cnt <= '0;
    end else if (accept) begin
      state <= SHIFT;
      cnt <= '0;
      shreg <= bus.data_in;
    end else if (last) begin
      state <= IDLE;
      cnt <= '0;
    end else if (state == SHIFT) begin
      cnt <= cnt + 1'b1;
      shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    end
  end
endmodule

// File: tb/tb_serial_bit_streamer.sv
// tb_serial_bit_streamer: directed checks of serialisation, back-to-back, abort and reset
module tb_serial_bit_streamer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  serial_bit_streamer_if #(.WIDTH(8)) b0 ();
  serial_bit_streamer_if #(.WIDTH(8)) b1 ();
  serial_bit_streamer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  serial_bit_streamer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] w;
    logic [15:0] ww;
    b0.data_in = '0; b0.data_valid = 0; b0.abort = 0;
    b1.data_in = '0; b1.data_valid = 0; b1.abort = 0;
    #2;
    chk("rst_bit_out", b0.bit_out, 0);
    chk("rst_bit_valid", b0.bit_valid, 0);
    chk("rst_last_bit", b0.last_bit, 0);
    chk("rst_ready", b0.data_ready, 1);
    chk("rst_ready_lsb", b1.data_ready, 1);
    @(negedge clk);
    rst_n = 1;
    tick;
    w = 8'b1011_0000;
    b0.data_in = w; b0.data_valid = 1;
    tick;
    b0.data_valid = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_bit%0d", i), b0.bit_out, w[7-i]);
      chk($sformatf("t1_valid%0d", i), b0.bit_valid, 1);
      chk($sformatf("t1_last%0d", i), b0.last_bit, i == 7);
      tick;
    end
    chk("t1_idle_valid", b0.bit_valid, 0);
    chk("t1_idle_bit", b0.bit_out, 0);
    chk("t1_idle_ready", b0.data_ready, 1);
    ww = 16'hA53C;
    chk("t2_ready0", b0.data_ready, 1);
    b0.data_in = 8'hA5; b0.data_valid = 1;
    tick;
    b0.data_in = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) b0.data_valid = 0;
      chk($sformatf("t2_bit%0d", i), b0.bit_out, ww[15-i]);
      chk($sformatf("t2_valid%0d", i), b0.bit_valid, 1);
      chk($sformatf("t2_ready%0d", i), b0.data_ready, (i == 7) || (i == 15));
      tick;
    end
    chk("t2_end_valid", b0.bit_valid, 0);
    chk("t2_end_ready", b0.data_ready, 1);
    w = 8'b0000_1101;
    b1.data_in = w; b1.data_valid = 1;
    tick;
    b1.data_valid = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_bit%0d", i), b1.bit_out, (i == 0) || (i == 2) || (i == 3));
      chk($sformatf("t3_last%0d", i), b1.last_bit, i == 7);
      tick;
    end
    chk("t3_idle_valid", b1.bit_valid, 0);
    b0.data_in = 8'hFF; b0.data_valid = 1;
    tick;
    b0.data_in = 8'h81;
    tick; tick; tick;
    chk("t4_bit3", b0.bit_out, 1);
    chk("t4_ready_busy", b0.data_ready, 0);
    b0.abort = 1;
    tick;
    b0.abort = 0;
    chk("t4_abort_bit", b0.bit_out, 0);
    chk("t4_abort_valid", b0.bit_valid, 0);
    chk("t4_abort_ready", b0.data_ready, 1);
    tick;
    b0.data_valid = 0;
    chk("t4_fresh_bit0", b0.bit_out, 1);
    chk("t4_fresh_valid", b0.bit_valid, 1);
    chk("t4_fresh_last", b0.last_bit, 0);
    tick;
    chk("t4_fresh_bit1", b0.bit_out, 0);
    tick;
    #3;
    rst_n = 0;
    #1;
    chk("t5_bit", b0.bit_out, 0);
    chk("t5_valid", b0.bit_valid, 0);
    chk("t5_ready", b0.data_ready, 1);
    chk("t5_last", b0.last_bit, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("t5_quiet%0d", i), b0.bit_valid, 0);
    end
    b0.data_in = 8'hFF; b0.data_valid = 1; b0.abort = 1;
    tick;
    b0.data_valid = 0; b0.abort = 0;
    chk("t6_valid", b0.bit_valid, 0);
    chk("t6_ready", b0.data_ready, 1);
    tick;
    chk("t6_valid_later", b0.bit_valid, 0);
    chk("t6_bit", b0.bit_out, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
